sprite_line_buffer: RTL and testbench



---
 rtl/sprite_line_buffer_pkg.sv | 17 +
 rtl/sprite_lb_bank.sv | 48 ++++
 rtl/sprite_line_buffer.sv | 175 +++++++++++++++++
 tb/tb_sprite_line_buffer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_line_buffer_pkg.sv
// Shared defaults for the sprite line buffer: line geometry, pen/priority widths, bank tags.
// Pure declarations; no timing or flow-control behaviour lives here.
package sprite_line_buffer_pkg;

    localparam int              LB_LINE_LEN        = 288;
    localparam int              LB_X_BITS          = 9;
    localparam int              LB_PIX_BITS        = 8;
    localparam int              LB_PRI_BITS        = 3;
    localparam logic [7:0]      LB_TRANSPARENT_PEN = 8'hFF;
    localparam int              LB_ENTRY_BITS      = LB_PIX_BITS + LB_PRI_BITS;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_e;

endpackage

// File: rtl/sprite_lb_bank.sv
// One line bank: pix/pri RAM (async read, sync write) plus valid flops with a clear port.
// Read is combinational; write and clear land on the clock edge, a same-cycle set beats a clear.
module sprite_lb_bank #(
    parameter int DEPTH    = 288,
    parameter int AW       = 9,
    parameter int PIX_BITS = 8,
    parameter int PRI_BITS = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [AW-1:0]       i_rd_addr,
    output logic                o_rd_vld,
    output logic [PIX_BITS-1:0] o_rd_pix,
    output logic [PRI_BITS-1:0] o_rd_pri,
    input  logic                i_we,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [PIX_BITS-1:0] i_wr_pix,
    input  logic [PRI_BITS-1:0] i_wr_pri,
    input  logic                i_clr,
    input  logic [AW-1:0]       i_clr_addr
);

    logic [PIX_BITS+PRI_BITS-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]             r_vld;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= {i_wr_pix, i_wr_pri};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
        end else begin
            if (i_clr) begin
                r_vld[i_clr_addr] <= 1'b0;
            end
            if (i_we) begin
                r_vld[i_wr_addr] <= 1'b1;
            end
        end
    end

    assign o_rd_vld               = r_vld[i_rd_addr];
    assign {o_rd_pix, o_rd_pri}   = r_mem[i_rd_addr];

endmodule

// File: rtl/sprite_line_buffer.sv
// Double-buffered sprite line buffer: 2-stage priority write pipe, 1-cycle registered readout,
// wr_ready drops only in the swap cycle and in reset. Optional reverse readout under SPRITE_LB_FLIP_EN.
module sprite_line_buffer
    import sprite_line_buffer_pkg::*;
#(
    parameter int                  LINE_LEN        = LB_LINE_LEN,
    parameter int                  X_BITS          = LB_X_BITS,
    parameter int                  PIX_BITS        = LB_PIX_BITS,
    parameter int                  PRI_BITS        = LB_PRI_BITS,
    parameter logic [PIX_BITS-1:0] TRANSPARENT_PEN = LB_TRANSPARENT_PEN
) (
    input  logic                CLK_6M,
    input  logic                rst,
`ifdef SPRITE_LB_FLIP_EN
    input  logic                flip,
`endif
    input  logic                nHSYNC,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [X_BITS-1:0]   wr_x,
    input  logic [PIX_BITS-1:0] wr_pix,
    input  logic [PRI_BITS-1:0] wr_pri,
    input  logic                rd_en,
    output logic [PIX_BITS-1:0] rd_pix,
    output logic [PRI_BITS-1:0] rd_pri,
    output logic                rd_opaque
);

    localparam logic [X_BITS-1:0] LAST_X = X_BITS'(LINE_LEN - 1);

    logic                r_nhs;
    bank_e               r_wbank;
    logic [X_BITS-1:0]   r_cnt;

    logic                r_p_vld;
    logic [X_BITS-1:0]   r_p_x;
    logic [PIX_BITS-1:0] r_p_pix;
    logic [PRI_BITS-1:0] r_p_pri;
    bank_e               r_p_bank;
    logic                r_p_st_vld;
    logic [PRI_BITS-1:0] r_p_st_pri;

    logic                w_swap, w_acc, w_commit, w_fwd;
    logic                w_flip, w_flip_next, w_done, w_in_range, w_rd_go;
    logic [X_BITS-1:0]   w_wr_addr, w_cnt_addr;
    logic                w_a_vld, w_b_vld, w_ws_vld, w_rs_vld;
    logic [PIX_BITS-1:0] w_a_pix, w_b_pix, w_rs_pix;
    logic [PRI_BITS-1:0] w_a_pri, w_b_pri, w_ws_pri, w_rs_pri;

    assign w_swap   = r_nhs & ~nHSYNC;
    assign wr_ready = ~rst & ~w_swap;
    assign w_acc    = wr_valid & wr_ready;

    assign w_wr_addr  = (wr_x <= LAST_X) ? wr_x : '0;
    assign w_in_range = (r_cnt <= LAST_X) & ~w_done;
    assign w_cnt_addr = w_in_range ? r_cnt : '0;
    assign w_rd_go    = rd_en & ~w_swap & w_in_range;

    assign w_ws_vld = (r_wbank == BANK_A) ? w_a_vld : w_b_vld;
    assign w_ws_pri = (r_wbank == BANK_A) ? w_a_pri : w_b_pri;
    assign w_rs_vld = (r_wbank == BANK_A) ? w_b_vld : w_a_vld;
    assign w_rs_pix = (r_wbank == BANK_A) ? w_b_pix : w_a_pix;
    assign w_rs_pri = (r_wbank == BANK_A) ? w_b_pri : w_a_pri;

    assign w_commit = r_p_vld && (r_p_pix != TRANSPARENT_PEN) && (r_p_x <= LAST_X) &&
                      (!r_p_st_vld || (r_p_pri >= r_p_st_pri));
    // The RAM has not yet seen the commit happening this cycle, so a same-x follow-up takes it from here.
    assign w_fwd    = w_commit && (r_p_x == wr_x) && (r_p_bank == r_wbank);

`ifdef SPRITE_LB_FLIP_EN
    logic r_flip, r_done;

    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            r_flip <= 1'b0;
            r_done <= 1'b0;
        end else if (w_swap) begin
            r_flip <= flip;
            r_done <= 1'b0;
        end else if (w_rd_go && r_flip && (r_cnt == '0)) begin
            r_done <= 1'b1;
        end
    end

    assign w_flip      = r_flip;
    assign w_flip_next = flip;
    assign w_done      = r_done;
`else
    assign w_flip      = 1'b0;
    assign w_flip_next = 1'b0;
    assign w_done      = 1'b0;
`endif

    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            r_nhs   <= 1'b0;
            r_wbank <= BANK_A;
            r_cnt   <= '0;
        end else begin
            r_nhs <= nHSYNC;
            if (w_swap) begin
                r_wbank <= (r_wbank == BANK_A) ? BANK_B : BANK_A;
                r_cnt   <= w_flip_next ? LAST_X : '0;
            end else if (w_rd_go) begin
                r_cnt   <= w_flip ? (r_cnt - 1'b1) : (r_cnt + 1'b1);
            end
        end
    end

    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            r_p_vld <= 1'b0;
        end else begin
            r_p_vld <= w_acc;
        end
    end

    always_ff @(posedge CLK_6M) begin
        if (w_acc) begin
            r_p_x      <= wr_x;
            r_p_pix    <= wr_pix;
            r_p_pri    <= wr_pri;
            r_p_bank   <= r_wbank;
            r_p_st_vld <= w_fwd | w_ws_vld;
            r_p_st_pri <= w_fwd ? r_p_pri : w_ws_pri;
        end
    end

    always_ff @(posedge CLK_6M) begin
        if (rst || !(w_rd_go && w_rs_vld)) begin
            rd_pix    <= TRANSPARENT_PEN;
            rd_pri    <= '0;
            rd_opaque <= 1'b0;
        end else begin
            rd_pix    <= w_rs_pix;
            rd_pri    <= w_rs_pri;
            rd_opaque <= 1'b1;
        end
    end

    sprite_lb_bank #(
        .DEPTH(LINE_LEN), .AW(X_BITS), .PIX_BITS(PIX_BITS), .PRI_BITS(PRI_BITS)
    ) u_bank_a (
        .i_clk      (CLK_6M),
        .i_rst      (rst),
        .i_rd_addr  ((r_wbank == BANK_A) ? w_wr_addr : w_cnt_addr),
        .o_rd_vld   (w_a_vld),
        .o_rd_pix   (w_a_pix),
        .o_rd_pri   (w_a_pri),
        .i_we       (w_commit && (r_p_bank == BANK_A)),
        .i_wr_addr  (r_p_x),
        .i_wr_pix   (r_p_pix),
        .i_wr_pri   (r_p_pri),
        .i_clr      (w_rd_go && (r_wbank == BANK_B)),
        .i_clr_addr (r_cnt)
    );

    sprite_lb_bank #(
        .DEPTH(LINE_LEN), .AW(X_BITS), .PIX_BITS(PIX_BITS), .PRI_BITS(PRI_BITS)
    ) u_bank_b (
        .i_clk      (CLK_6M),
        .i_rst      (rst),
        .i_rd_addr  ((r_wbank == BANK_B) ? w_wr_addr : w_cnt_addr),
        .o_rd_vld   (w_b_vld),
        .o_rd_pix   (w_b_pix),
        .o_rd_pri   (w_b_pri),
        .i_we       (w_commit && (r_p_bank == BANK_B)),
        .i_wr_addr  (r_p_x),
        .i_wr_pix   (r_p_pix),
        .i_wr_pri   (r_p_pri),
        .i_clr      (w_rd_go && (r_wbank == BANK_A)),
        .i_clr_addr (r_cnt)
    );

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Bench for sprite_line_buffer: scenario tasks plus randomized lines against a line-level model.
// Observed/expected words are {wr_ready, rd_opaque, rd_pri, rd_pix}.
module tb_sprite_line_buffer;

    localparam int LEN = 288;

    logic       CLK_6M;
    logic       rst;
    logic       flip_sel;
    logic       nHSYNC;
    logic       wr_valid;
    logic       wr_ready;
    logic [8:0] wr_x;
    logic [7:0] wr_pix;
    logic [2:0] wr_pri;
    logic       rd_en;
    logic [7:0] rd_pix;
    logic [2:0] rd_pri;
    logic       rd_opaque;

    sprite_line_buffer dut (
        .CLK_6M    (CLK_6M),
        .rst       (rst),
`ifdef SPRITE_LB_FLIP_EN
        .flip      (flip_sel),
`endif
        .nHSYNC    (nHSYNC),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_pix    (wr_pix),
        .wr_pri    (wr_pri),
        .rd_en     (rd_en),
        .rd_pix    (rd_pix),
        .rd_pri    (rd_pri),
        .rd_opaque (rd_opaque)
    );

    initial CLK_6M = 1'b0;
    always #5 CLK_6M = ~CLK_6M;

    int          total = 0;
    int          bad   = 0;
    logic [12:0] o, e;

    // Line-level model: two arrays of sprite pixels, a write-bank index and a read position.
    bit          mv   [2][LEN];
    logic [7:0]  mpix [2][LEN];
    logic [2:0]  mpri [2][LEN];
    int          m_wb, m_cnt;
    bit          m_flip, m_hs_q;

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < LEN; k++) mv[b][k] = 1'b0;
        m_wb = 0; m_cnt = 0; m_flip = 1'b0; m_hs_q = 1'b0;
    endtask

    task automatic cycle(input bit ren, input bit wv, input logic [8:0] x, input logic [7:0] pix,
                         input logic [2:0] pri, input bit hs,
                         output logic [12:0] obs, output logic [12:0] exp);
        bit swap;
        int rb;
        logic e_op;
        logic [7:0] e_pix;
        logic [2:0] e_pri;
        swap  = m_hs_q && !hs;
        e_op  = 1'b0; e_pix = 8'hFF; e_pri = 3'd0;
        if (ren && !swap && m_cnt >= 0 && m_cnt < LEN) begin
            rb = 1 - m_wb;
            if (mv[rb][m_cnt]) begin
                e_op = 1'b1; e_pix = mpix[rb][m_cnt]; e_pri = mpri[rb][m_cnt];
            end
            mv[rb][m_cnt] = 1'b0;
            m_cnt = m_flip ? m_cnt - 1 : m_cnt + 1;
        end
        if (wv && !swap && pix != 8'hFF && int'(x) < LEN) begin
            if (!mv[m_wb][x] || pri >= mpri[m_wb][x]) begin
                mv[m_wb][x] = 1'b1; mpix[m_wb][x] = pix; mpri[m_wb][x] = pri;
            end
        end
        if (swap) begin
            m_wb   = 1 - m_wb;
            m_flip = flip_sel;
            m_cnt  = m_flip ? LEN - 1 : 0;
        end
        m_hs_q = hs;
        exp = {!swap, e_op, e_pri, e_pix};

        rd_en = ren; wr_valid = wv; wr_x = x; wr_pix = pix; wr_pri = pri; nHSYNC = hs;
        #1;
        obs[12] = wr_ready;
        @(posedge CLK_6M);
        #1;
        obs[11:0] = {rd_opaque, rd_pri, rd_pix};
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_pix = '0; wr_pri = '0; nHSYNC = 1'b1;
        repeat (2) begin
            @(posedge CLK_6M);
            #1;
        end
        total++;
        if (wr_ready !== 1'b0) begin
            bad++; $display("FAIL reset_wr_ready got=%b want=0", wr_ready);
        end
        total++;
        if ({rd_opaque, rd_pri, rd_pix} !== {1'b0, 3'd0, 8'hFF}) begin
            bad++; $display("FAIL reset_outputs got=%h want=%h", {rd_opaque, rd_pri, rd_pix}, {1'b0, 3'd0, 8'hFF});
        end
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0, 9'd0, 8'd0, 3'd0, 1'b1, o, e);
        total++;
        if (o !== e) begin
            bad++; $display("FAIL reset_release got=%h want=%h", o, e);
        end
    endtask

    task automatic test_empty_line();
        for (int i = 0; i < LEN + 2; i++) begin
            cycle(i != 0, 1'b0, 9'd0, 8'd0, 3'd0, i != 0, o, e);
            total++;
            if (o !== e || o[11:0] !== {1'b0, 3'd0, 8'hFF}) begin
                bad++; $display("FAIL empty_line i=%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_single_pixel();
        for (int l = 0; l < 3; l++) begin
            if (l == 0) begin
                cycle(1'b0, 1'b1, 9'd5, 8'h12, 3'd2, 1'b1, o, e);
                total++;
                if (o !== e) begin
                    bad++; $display("FAIL single_write got=%h want=%h", o, e);
                end
            end
            for (int i = 0; i < LEN + 2; i++) begin
                cycle(i != 0, 1'b0, 9'd0, 8'd0, 3'd0, i != 0, o, e);
                total++;
                if (o !== e) begin
                    bad++; $display("FAIL single_line l=%0d i=%0d got=%h want=%h", l, i, o, e);
                end
                if (i == 6) begin
                    total++;
                    if (o[11:0] !== ((l == 0) ? {1'b1, 3'd2, 8'h12} : {1'b0, 3'd0, 8'hFF})) begin
                        bad++; $display("FAIL single_x5 l=%0d got=%h", l, o[11:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [7:0] pixs [3] = '{8'h20, 8'h30, 8'h40};
        logic [2:0] pris [3] = '{3'd3, 3'd1, 3'd3};
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 2 + l; k++) begin
                cycle(1'b0, 1'b1, 9'd10, pixs[k], pris[k], 1'b1, o, e);
                total++;
                if (o !== e) begin
                    bad++; $display("FAIL prio_write l=%0d k=%0d got=%h want=%h", l, k, o, e);
                end
            end
            for (int i = 0; i < LEN + 2; i++) begin
                cycle(i != 0, 1'b0, 9'd0, 8'd0, 3'd0, i != 0, o, e);
                total++;
                if (o !== e) begin
                    bad++; $display("FAIL prio_line l=%0d i=%0d got=%h want=%h", l, i, o, e);
                end
                if (i == 11) begin
                    total++;
                    if (o[11:0] !== {1'b1, 3'd3, (l == 0) ? 8'h20 : 8'h40}) begin
                        bad++; $display("FAIL prio_x10 l=%0d got=%h", l, o[11:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_drop();
        cycle(1'b0, 1'b1, 9'd0, 8'hFF, 3'd5, 1'b1, o, e);
        total++;
        if (o !== e || o[12] !== 1'b1) begin
            bad++; $display("FAIL drop_pen got=%h want=%h", o, e);
        end
        cycle(1'b0, 1'b1, 9'd300, 8'h11, 3'd5, 1'b1, o, e);
        total++;
        if (o !== e || o[12] !== 1'b1) begin
            bad++; $display("FAIL drop_range got=%h want=%h", o, e);
        end
        for (int i = 0; i < LEN + 2; i++) begin
            cycle(i != 0, 1'b0, 9'd0, 8'd0, 3'd0, i != 0, o, e);
            total++;
            if (o !== e || o[11] !== 1'b0) begin
                bad++; $display("FAIL drop_line i=%0d got=%h want=%h", i, o, e);
            end
        end
    endtask

    task automatic test_before_swap();
        cycle(1'b0, 1'b1, 9'd7, 8'h77, 3'd4, 1'b1, o, e);
        total++;
        if (o !== e) begin
            bad++; $display("FAIL preswap_write got=%h want=%h", o, e);
        end
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < LEN + 2; i++) begin
                // a write offered in the swap cycle itself must be refused
                cycle(i != 0, i == 0, 9'd9, 8'h99, 3'd7, i != 0, o, e);
                total++;
                if (o !== e) begin
                    bad++; $display("FAIL preswap_line l=%0d i=%0d got=%h want=%h", l, i, o, e);
                end
                if (l == 0 && i == 8) begin
                    total++;
                    if (o[11:0] !== {1'b1, 3'd4, 8'h77}) begin
                        bad++; $display("FAIL preswap_x7 got=%h", o[11:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int len;
        bit ren, wv;
        logic [8:0] x;
        logic [7:0] pix;
        logic [2:0] pri;
        for (int l = 0; l < 8; l++) begin
            len = (l < 6) ? int'($urandom_range(200, 300)) : LEN + 2;
            for (int i = 0; i < len; i++) begin
                ren = (l >= 6) || ($urandom_range(3) != 0);
                wv  = (l < 6) && ($urandom_range(1) == 1);
                x   = $urandom_range(1) ? 9'($urandom_range(15)) : 9'($urandom_range(319));
                pix = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
                pri = 3'($urandom);
                cycle(ren, wv, x, pix, pri, i != 0, o, e);
                total++;
                if (o !== e) begin
                    bad++; $display("FAIL random l=%0d i=%0d got=%h want=%h", l, i, o, e);
                end
            end
        end
    endtask

    task automatic test_reset_clears();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 9'(3 + k), 8'h3C, 3'd6, 1'b1, o, e);
        end
        test_reset();
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < LEN + 2; i++) begin
                cycle(i != 0, 1'b0, 9'd0, 8'd0, 3'd0, i != 0, o, e);
                total++;
                if (o !== e || o[11] !== 1'b0) begin
                    bad++; $display("FAIL reset_clears l=%0d i=%0d got=%h want=%h", l, i, o, e);
                end
            end
        end
    endtask

`ifdef SPRITE_LB_FLIP_EN
    task automatic test_flip();
        flip_sel = 1'b1;
        cycle(1'b0, 1'b1, 9'd0, 8'h55, 3'd1, 1'b1, o, e);
        cycle(1'b0, 1'b1, 9'd287, 8'h66, 3'd1, 1'b1, o, e);
        for (int i = 0; i < LEN + 2; i++) begin
            cycle(i != 0, 1'b0, 9'd0, 8'd0, 3'd0, i != 0, o, e);
            total++;
            if (o !== e) begin
                bad++; $display("FAIL flip_line i=%0d got=%h want=%h", i, o, e);
            end
            if (i == 1 || i == LEN) begin
                total++;
                if (o[11:0] !== {1'b1, 3'd1, (i == 1) ? 8'h66 : 8'h55}) begin
                    bad++; $display("FAIL flip_edge i=%0d got=%h", i, o[11:0]);
                end
            end
        end
        flip_sel = 1'b0;
    endtask
`endif

    initial begin
        flip_sel = 1'b0;
        test_reset();
        test_empty_line();
        test_single_pixel();
        test_priority();
        test_drop();
        test_before_swap();
`ifdef SPRITE_LB_FLIP_EN
        test_flip();
`endif
        test_random();
        test_reset_clears();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
